// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_pkg: shared types and helpers for the IF-stage PC controller.
// Holds the FSM state encoding, the next-PC source encoding, the PC width
// and the alignment check used on redirect targets.
package pc_fetch_pkg;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  // Which source feeds the next PC, lowest to highest priority.
  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    PEND = 2'd1,
    BR   = 2'd2,
    JMP  = 2'd3
  } redir_src_e;

  // Word-aligned instruction address: low two bits must be zero.
  function automatic logic is_aligned(input logic [PC_W-1:0] addr);
    return (addr & PC_W'(3)) == '0;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: fetch handshake, PC adder loop, redirect and error
// signals between the PC controller (master) and its surroundings (slave).
interface pc_fetch_ctrl_if;
  import pc_fetch_pkg::*;

  // PC adder loop and instruction-memory request
  logic [PC_W-1:0] PCResult;
  logic [PC_W-1:0] PCAddResult;
  logic            FetchValid;
  logic            FetchReady;

  // Hazard and redirect inputs
  logic            Stall;
  logic            BranchTaken;
  logic [PC_W-1:0] BranchTarget;
  logic            Jump;
  logic [PC_W-1:0] JumpTarget;

  // Error reporting and recovery
  logic            ErrClr;
  logic            MisalignErr;
  logic [PC_W-1:0] ErrAddr;

  modport master (
    input  PCAddResult, FetchReady, Stall, BranchTaken, BranchTarget,
           Jump, JumpTarget, ErrClr,
    output PCResult, FetchValid, MisalignErr, ErrAddr
  );

  modport slave (
    output PCAddResult, FetchReady, Stall, BranchTaken, BranchTarget,
           Jump, JumpTarget, ErrClr,
    input  PCResult, FetchValid, MisalignErr, ErrAddr
  );

endinterface

// File: rtl/pc_fetch_ctrl_trace_buffer.sv
// pc_trace_buffer: circular record of the last DEPTH applied redirect
// targets. Index 0 on the read port is the newest entry; the oldest entry
// is overwritten once the buffer is full. DEPTH must be a power of 2 (>= 2)
// so the write pointer wraps on its own.
module pc_trace_buffer
  import pc_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [PC_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] idx,
  output logic [PC_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Write the newest target, advance the pointer, saturate the count
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is tiny and its reads are visible on a port, so it is
      // reset explicitly; a large RAM would normally be left unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= wr_ptr + AW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end
  end

  // Newest entry sits one slot behind the write pointer
  assign rd_ptr = wr_ptr - AW'(1) - idx;
  assign rdata  = mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and next-PC controller at the
// head of the IF stage. Selects Jump > BranchTaken > pending > PC+4, holds
// the PC whenever a fetch is not accepted, parks redirects that arrive
// without an accepted fetch, and stops in ERR on a misaligned redirect.
// Optional feature macro: PC_TRACE_EN adds a redirect trace buffer and the
// TraceIdx/TraceData/TraceCount ports; without it the core is unchanged.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_TRACE_EN
  , parameter int TRACE_DEPTH = 4
`endif
) (
  input  logic                           Clk,
  input  logic                           Reset,
  pc_fetch_ctrl_if.master                bus
`ifdef PC_TRACE_EN
  , input  logic [$clog2(TRACE_DEPTH)-1:0] TraceIdx
  , output logic [PC_W-1:0]                TraceData
  , output logic [$clog2(TRACE_DEPTH):0]   TraceCount
`endif
);

  state_e          state;
  logic [PC_W-1:0] pc_q;
  logic            fetch_valid_q;
  logic            err_q;
  logic [PC_W-1:0] err_addr_q;
  logic            pend_v;
  logic [PC_W-1:0] pend_q;

  logic            adv;
  redir_src_e      sel_src;
  logic [PC_W-1:0] sel_target;
  logic            new_redirect;
  logic            misalign;

  // A fetch is accepted only while a request is up, memory takes it and no stall
  assign adv = fetch_valid_q & bus.FetchReady & ~bus.Stall;

  // Next-PC source select by fixed priority
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    sel_src    = SEQ;
    sel_target = bus.PCAddResult;
    if (bus.Jump) begin
      sel_src    = JMP;
      sel_target = bus.JumpTarget;
    end else if (bus.BranchTaken) begin
      sel_src    = BR;
      sel_target = bus.BranchTarget;
    end else if (pend_v) begin
      sel_src    = PEND;
      sel_target = pend_q;
    end
  end

  // Pending targets were checked on capture, so only fresh redirects can misalign
  assign new_redirect = (sel_src == JMP) || (sel_src == BR);
  assign misalign     = new_redirect && !is_aligned(sel_target);

  // FSM, PC register, pending redirect and error capture
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: reset is synchronous and checked first, so it overrides every
      // other input; all state uses non-blocking assignments so the block
      // sees only pre-edge values.
      state         <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_addr_q    <= '0;
      pend_v        <= 1'b0;
      pend_q        <= '0;
    end else begin
      case (state)
        ERR: begin
          // Redirects are dropped here; only ErrClr restarts fetching.
          if (bus.ErrClr) begin
            state <= BOOT;
            pc_q  <= RESET_VECTOR;
            err_q <= 1'b0;
          end
        end
        default: begin
          if (misalign) begin
            state         <= ERR;
            fetch_valid_q <= 1'b0;
            err_q         <= 1'b1;
            err_addr_q    <= sel_target;
            pend_v        <= 1'b0;
          end else begin
            // BOOT always falls through to RUN after one cycle.
            state         <= RUN;
            fetch_valid_q <= 1'b1;
            if (adv) begin
              pc_q   <= sel_target;
              pend_v <= 1'b0;
            end else if (new_redirect) begin
              // Latest redirect wins; PC stays put until the fetch is taken.
              pend_q <= sel_target;
              pend_v <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.PCResult    = pc_q;
  assign bus.FetchValid  = fetch_valid_q;
  assign bus.MisalignErr = err_q;
  assign bus.ErrAddr     = err_addr_q;

`ifdef PC_TRACE_EN
  logic trace_we;

  // Record a target each time a redirect or a parked redirect reaches the PC
  assign trace_we = adv && (sel_src != SEQ) && !misalign;

  pc_trace_buffer #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk   (Clk),
    .rst   (Reset),
    .we    (trace_we),
    .wdata (sel_target),
    .idx   (TraceIdx),
    .rdata (TraceData),
    .count (TraceCount)
  );
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the fetch controller.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          TD = 4;

  logic Clk = 1'b0;
  logic Reset;

  pc_fetch_ctrl_if bus ();

`ifdef PC_TRACE_EN
  logic [1:0]  TraceIdx;
  logic [31:0] TraceData;
  logic [2:0]  TraceCount;
`endif

  // The PC+4 adder lives outside the controller
  assign bus.PCAddResult = bus.PCResult + 32'd4;

  pc_fetch_ctrl #(
    .RESET_VECTOR (RV)
`ifdef PC_TRACE_EN
    , .TRACE_DEPTH (TD)
`endif
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
`ifdef PC_TRACE_EN
    , .TraceIdx   (TraceIdx)
    , .TraceData  (TraceData)
    , .TraceCount (TraceCount)
`endif
  );

  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: architectural view of the controller
  logic [31:0] m_pc;
  logic [31:0] m_err_addr;
  bit          m_boot;
  bit          m_halt;
  bit          m_err;
  logic [31:0] m_pend [$];
  logic [31:0] m_tr [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic trace_push(input logic [31:0] t);
    m_tr.push_front(t);
    if (m_tr.size() > TD) void'(m_tr.pop_back());
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    logic [31:0] t;
    bit has;
    bit take;
    if (Reset) begin
      m_pc = RV; m_err_addr = 32'h0; m_boot = 1; m_halt = 0; m_err = 0;
      m_pend.delete();
      m_tr.delete();
    end else if (m_halt) begin
      if (bus.ErrClr) begin
        m_halt = 0; m_boot = 1; m_pc = RV; m_err = 0;
      end
    end else begin
      take = !m_boot && bus.FetchReady && !bus.Stall;
      has  = 0;
      t    = 32'h0;
      if (bus.Jump) begin
        has = 1; t = bus.JumpTarget;
      end else if (bus.BranchTaken) begin
        has = 1; t = bus.BranchTarget;
      end
      if (has && (t % 4) != 0) begin
        m_halt = 1; m_boot = 0; m_err = 1; m_err_addr = t;
        m_pend.delete();
      end else begin
        m_boot = 0;
        if (has && take) begin
          m_pc = t; m_pend.delete(); trace_push(t);
        end else if (has) begin
          m_pend.delete(); m_pend.push_back(t);
        end else if (take && m_pend.size() > 0) begin
          m_pc = m_pend.pop_front(); trace_push(m_pc);
        end else if (take) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // One clock: update model, let the edge pass, compare all outputs
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    check("pc", bus.PCResult, m_pc);
    check("valid", 32'(bus.FetchValid), 32'(!m_boot && !m_halt));
    check("misalign", 32'(bus.MisalignErr), 32'(m_err));
    check("erraddr", bus.ErrAddr, m_err_addr);
`ifdef PC_TRACE_EN
    check("tcount", 32'(TraceCount), 32'((m_tr.size() < TD) ? m_tr.size() : TD));
    check("tdata", TraceData, (int'(TraceIdx) < m_tr.size()) ? m_tr[TraceIdx] : 32'h0);
`endif
  endtask

  task automatic idle();
    bus.Jump         = 1'b0;
    bus.JumpTarget   = 32'h0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 32'h0;
    bus.Stall        = 1'b0;
    bus.FetchReady   = 1'b1;
    bus.ErrClr       = 1'b0;
  endtask

  initial begin
    logic [31:0] frozen;
    idle();
    Reset = 1'b1;
`ifdef PC_TRACE_EN
    TraceIdx = 2'd0;
`endif

    // 1: reset, then BOOT, then sequential fetch
    repeat (3) tick();
    check("t1_rst_pc", bus.PCResult, 32'h0);
    check("t1_boot_valid", 32'(bus.FetchValid), 32'd0);
    Reset = 1'b0;
    tick();
    check("t1_run_valid", 32'(bus.FetchValid), 32'd1);
    check("t1_pc0", bus.PCResult, 32'h0);
    tick();
    check("t1_pc4", bus.PCResult, 32'h4);
    tick();
    check("t1_pc8", bus.PCResult, 32'h8);

    // 2: branch arrives while memory is not ready
    bus.Jump = 1'b1; bus.JumpTarget = 32'h40;
    tick();
    check("t2_pc40", bus.PCResult, 32'h40);
    idle();
    bus.FetchReady = 1'b0;
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h100;
    tick();
    bus.BranchTaken = 1'b0;
    tick();
    tick();
    check("t2_hold", bus.PCResult, 32'h40);
    bus.FetchReady = 1'b1;
    tick();
    check("t2_pend_applied", bus.PCResult, 32'h100);
    tick();
    check("t2_after", bus.PCResult, 32'h104);

    // 3: jump beats branch in the same cycle
    bus.Jump = 1'b1; bus.JumpTarget = 32'h200;
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h300;
    tick();
    check("t3_jump_wins", bus.PCResult, 32'h200);
    idle();

    // 4: wrap at the top of the address space
    bus.Jump = 1'b1; bus.JumpTarget = 32'hFFFF_FFFC;
    tick();
    idle();
    tick();
    check("t4_wrap", bus.PCResult, 32'h0);
    check("t4_noerr", 32'(bus.MisalignErr), 32'd0);
    tick();

    // 5: misaligned jump, ignored redirects, then recovery
    frozen = bus.PCResult;
    bus.Jump = 1'b1; bus.JumpTarget = 32'h102;
    tick();
    check("t5_err", 32'(bus.MisalignErr), 32'd1);
    check("t5_erraddr", bus.ErrAddr, 32'h102);
    check("t5_valid", 32'(bus.FetchValid), 32'd0);
    check("t5_frozen", bus.PCResult, frozen);
    idle();
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h500;
    tick();
    check("t5_ignored", bus.PCResult, frozen);
    idle();
    bus.ErrClr = 1'b1;
    tick();
    check("t5_clr_pc", bus.PCResult, RV);
    check("t5_clr_err", 32'(bus.MisalignErr), 32'd0);
    check("t5_clr_boot", 32'(bus.FetchValid), 32'd0);
    check("t5_keep_addr", bus.ErrAddr, 32'h102);
    bus.ErrClr = 1'b0;
    tick();
    check("t5_run", 32'(bus.FetchValid), 32'd1);
    tick();

`ifdef PC_TRACE_EN
    // 6: five redirects into a four-entry trace, then reset
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus.Jump = 1'b1; bus.JumpTarget = 32'(i * 16);
      tick();
    end
    idle();
    TraceIdx = 2'd0; #1;
    check("t6_newest", TraceData, 32'h50);
    TraceIdx = 2'd3; #1;
    check("t6_oldest", TraceData, 32'h20);
    check("t6_count", 32'(TraceCount), 32'd4);
    Reset = 1'b1;
    tick();
    check("t6_rst_count", 32'(TraceCount), 32'd0);
    Reset = 1'b0;
`endif

    // Randomized traffic against the model
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int n = 0; n < 800; n++) begin
      logic [31:0] jt, bt;
      jt = $urandom & 32'hFFFF_FFFC;
      bt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 11) == 0) jt = jt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 11) == 0) bt = bt | 32'($urandom_range(1, 3));
      bus.Jump         = ($urandom_range(0, 9) == 0);
      bus.JumpTarget   = jt;
      bus.BranchTaken  = ($urandom_range(0, 6) == 0);
      bus.BranchTarget = bt;
      bus.Stall        = ($urandom_range(0, 3) == 0);
      bus.FetchReady   = ($urandom_range(0, 9) < 7);
      bus.ErrClr       = ($urandom_range(0, 3) == 0);
      Reset            = ($urandom_range(0, 99) == 0);
`ifdef PC_TRACE_EN
      TraceIdx = 2'($urandom_range(0, 3));
`endif
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
